// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM states, coin values and product prices.
package vend_pkg;

  localparam int unsigned CREDIT_W = 6;

  localparam logic [CREDIT_W-1:0] COIN_NICKLE  = 6'd5;
  localparam logic [CREDIT_W-1:0] COIN_DIME    = 6'd10;
  localparam logic [CREDIT_W-1:0] COIN_QUARTER = 6'd25;

  localparam logic [CREDIT_W-1:0] PRICE [4] = '{6'd20, 6'd25, 6'd35, 6'd45};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_DISPENSE,
    ST_PAYOUT
  } vend_state_e;

  function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] sel);
    return PRICE[sel];
  endfunction

endpackage

// File: rtl/change_payout.sv
// Change dispenser: loads an amount on start_i, then emits one dime/nickle pulse per cycle, dimes first.
module change_payout
  import vend_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [CREDIT_W-1:0] amount_i,
  output logic                pay_dime_o,
  output logic                pay_nickle_o,
  output logic                done_o,
  output logic [CREDIT_W-1:0] remaining_o
);

  logic [CREDIT_W-1:0] rem_q;
  logic [CREDIT_W-1:0] src;
  logic                dime_q;
  logic                nickle_q;

  // The first pulse comes out of the same edge that loads the amount.
  always_comb begin
    src = start_i ? amount_i : rem_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q    <= '0;
      dime_q   <= 1'b0;
      nickle_q <= 1'b0;
    end else if (src >= COIN_DIME) begin
      rem_q    <= src - COIN_DIME;
      dime_q   <= 1'b1;
      nickle_q <= 1'b0;
    end else if (src >= COIN_NICKLE) begin
      rem_q    <= src - COIN_NICKLE;
      dime_q   <= 1'b0;
      nickle_q <= 1'b1;
    end else begin
      rem_q    <= '0;
      dime_q   <= 1'b0;
      nickle_q <= 1'b0;
    end
  end

  assign pay_dime_o   = dime_q;
  assign pay_nickle_o = nickle_q;
  assign done_o       = (dime_q | nickle_q) && (rem_q == '0);
  assign remaining_o  = rem_q;

endmodule

// File: rtl/vend_controller.sv
// Vending transaction sequencer: coin credit, priced 4-way selection, dispenser handshake, change payout.
// Optional CREDIT-state inactivity refund is enabled with `define VEND_TIMEOUT_EN.
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned MAX_CREDIT     = 60,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                nickle_i,
  input  logic                dime_i,
  input  logic                quarter_i,
  input  logic                sel_valid_i,
  input  logic [1:0]          sel_i,
  input  logic                cancel_i,
  input  logic                dispense_ack_i,
  output logic                dispense_req_o,
  output logic [1:0]          product_o,
  output logic                pay_dime_o,
  output logic                pay_nickle_o,
  output logic                coin_reject_o,
  output logic                denied_o,
  output logic                busy_o,
  output logic [CREDIT_W-1:0] credit_o
);

  vend_state_e         state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [1:0]          product_q;
  logic                coin_reject_q;
  logic                denied_q;

  logic                open_st;
  logic [1:0]          n_coins;
  logic                coin_any;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok;
  logic                coin_rej;
  logic [CREDIT_W-1:0] credit_next;
  logic [CREDIT_W-1:0] price;
  logic                cancel_take;
  logic                sel_take;
  logic                sel_ok;
  logic                sel_deny;
  logic [CREDIT_W-1:0] remaining;
  logic                tmo_fire;
  logic                pay_start;
  logic                pay_done;
  logic [CREDIT_W-1:0] pay_rem;

  always_comb begin
    open_st     = (state_q == ST_IDLE) || (state_q == ST_CREDIT);
    n_coins     = {1'b0, nickle_i} + {1'b0, dime_i} + {1'b0, quarter_i};
    coin_any    = nickle_i | dime_i | quarter_i;
    coin_val    = '0;
    if (quarter_i)     coin_val = COIN_QUARTER;
    else if (dime_i)   coin_val = COIN_DIME;
    else if (nickle_i) coin_val = COIN_NICKLE;
    coin_sum    = {1'b0, credit_q} + {1'b0, coin_val};
    cancel_take = (state_q == ST_CREDIT) && cancel_i;
    // A coin arriving with a cancel is handed back rather than folded into the refund.
    coin_ok     = open_st && !cancel_take && (n_coins == 2'd1)
                  && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    coin_rej    = coin_any && !coin_ok;
    credit_next = coin_ok ? coin_sum[CREDIT_W-1:0] : credit_q;
    price       = price_of(sel_i);
    sel_take    = open_st && sel_valid_i && !cancel_take;
    sel_ok      = sel_take && (credit_q >= price);
    sel_deny    = sel_take && !sel_ok;
    remaining   = sel_ok ? (credit_next - price) : '0;
    pay_start   = cancel_take || tmo_fire
                  || ((state_q == ST_DISPENSE) && dispense_ack_i && (credit_q != '0));
  end

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] idle_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idle_cnt_q <= '0;
    end else if ((state_q != ST_CREDIT) || coin_ok || sel_deny) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end

  assign tmo_fire = (state_q == ST_CREDIT) && !cancel_take && !sel_take && !coin_ok
                    && (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_fire = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      product_q     <= '0;
      coin_reject_q <= 1'b0;
      denied_q      <= 1'b0;
    end else begin
      coin_reject_q <= coin_rej;
      denied_q      <= sel_deny;
      case (state_q)
        ST_IDLE, ST_CREDIT: begin
          if (cancel_take || tmo_fire) begin
            state_q  <= ST_PAYOUT;
            credit_q <= '0;
          end else if (sel_ok) begin
            state_q   <= ST_DISPENSE;
            credit_q  <= remaining;
            product_q <= sel_i;
          end else begin
            credit_q <= credit_next;
            state_q  <= (credit_next != '0) ? ST_CREDIT : ST_IDLE;
          end
        end
        ST_DISPENSE: begin
          if (dispense_ack_i) begin
            state_q   <= (credit_q != '0) ? ST_PAYOUT : ST_IDLE;
            credit_q  <= '0;
            product_q <= '0;
          end
        end
        ST_PAYOUT: begin
          if (pay_done) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  change_payout u_payout (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (pay_start),
    .amount_i     (credit_q),
    .pay_dime_o   (pay_dime_o),
    .pay_nickle_o (pay_nickle_o),
    .done_o       (pay_done),
    .remaining_o  (pay_rem)
  );

  assign dispense_req_o = (state_q == ST_DISPENSE);
  assign product_o      = product_q;
  assign coin_reject_o  = coin_reject_q;
  assign denied_o       = denied_q;
  assign busy_o         = (state_q == ST_DISPENSE) || (state_q == ST_PAYOUT);
  assign credit_o       = (state_q == ST_PAYOUT) ? pay_rem : credit_q;

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: directed stimulus queues expected events, a monitor pops and compares.
module tb_vend_controller;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       nickle_i = 1'b0, dime_i = 1'b0, quarter_i = 1'b0;
  logic       sel_valid_i = 1'b0;
  logic [1:0] sel_i = 2'd0;
  logic       cancel_i = 1'b0;
  logic       dispense_ack_i = 1'b0;
  logic       dispense_req_o;
  logic [1:0] product_o;
  logic       pay_dime_o, pay_nickle_o, coin_reject_o, denied_o, busy_o;
  logic [5:0] credit_o;

  vend_controller #(.MAX_CREDIT(60), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .nickle_i(nickle_i), .dime_i(dime_i), .quarter_i(quarter_i),
    .sel_valid_i(sel_valid_i), .sel_i(sel_i), .cancel_i(cancel_i),
    .dispense_ack_i(dispense_ack_i),
    .dispense_req_o(dispense_req_o), .product_o(product_o),
    .pay_dime_o(pay_dime_o), .pay_nickle_o(pay_nickle_o),
    .coin_reject_o(coin_reject_o), .denied_o(denied_o),
    .busy_o(busy_o), .credit_o(credit_o)
  );

  always #5 clk_i = ~clk_i;

  typedef enum int {EV_REJECT, EV_DENY, EV_REQ, EV_DIME, EV_NICK} ev_e;
  typedef struct {
    ev_e kind;
    int  prod;
    int  cred;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  logic req_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input ev_e k, input int p, input int c);
    exp_t e;
    e.kind = k; e.prod = p; e.cred = c;
    sbq.push_back(e);
  endtask

  task automatic sb_pop(input ev_e k, input int p, input int c);
    exp_t e;
    if (sbq.size() == 0) begin
      check("sb_unexpected_event", k, 32'hFFFF_FFFF);
    end else begin
      e = sbq.pop_front();
      check("sb_kind", k, e.kind);
      if (e.kind == EV_REQ) check("sb_product", p, e.prod);
      if (e.kind == EV_REQ || e.kind == EV_DIME || e.kind == EV_NICK)
        check("sb_credit", c, e.cred);
    end
  endtask

  // Monitor: every output event seen on the falling edge is matched against the queue.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      req_prev = 1'b0;
    end else begin
      if (coin_reject_o) sb_pop(EV_REJECT, 0, 0);
      if (denied_o) sb_pop(EV_DENY, 0, 0);
      if (dispense_req_o && !req_prev) sb_pop(EV_REQ, int'(product_o), int'(credit_o));
      if (pay_dime_o) sb_pop(EV_DIME, 0, int'(credit_o));
      if (pay_nickle_o) sb_pop(EV_NICK, 0, int'(credit_o));
      req_prev = dispense_req_o;
    end
  end

  task automatic cyc(input logic n, input logic d, input logic q, input logic sv,
                     input logic [1:0] s, input logic c, input logic a);
    nickle_i = n; dime_i = d; quarter_i = q;
    sel_valid_i = sv; sel_i = s; cancel_i = c; dispense_ack_i = a;
    @(posedge clk_i); #1;
    nickle_i = 0; dime_i = 0; quarter_i = 0;
    sel_valid_i = 0; sel_i = 0; cancel_i = 0; dispense_ack_i = 0;
  endtask

  task automatic idle(input int k);
    repeat (k) cyc(0, 0, 0, 0, 2'd0, 0, 0);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy_o && k < 30) begin
      @(posedge clk_i); #1;
      k++;
    end
    check({name, "_busy"}, busy_o, 0);
    check({name, "_credit"}, credit_o, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    #12;
    check("rst_req", dispense_req_o, 0);
    check("rst_credit", credit_o, 0);
    check("rst_pulses", {pay_dime_o, pay_nickle_o, coin_reject_o, denied_o}, 0);
    check("rst_busy", busy_o, 0);
    check("rst_product", product_o, 0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Quarter, select 0, ack: one nickle back.
    cyc(0, 0, 1, 0, 2'd0, 0, 0);
    check("t1_credit", credit_o, 25);
    expect_ev(EV_REQ, 0, 5);
    cyc(0, 0, 0, 1, 2'd0, 0, 0);
    check("t1_req", dispense_req_o, 1);
    expect_ev(EV_NICK, 0, 0);
    cyc(0, 0, 0, 0, 2'd0, 0, 1);
    check("t1_req_drop", dispense_req_o, 0);
    wait_idle("t1");

    // Over-ceiling quarter rejected at 50; select 3 leaves 5.
    cyc(0, 0, 1, 0, 2'd0, 0, 0);
    cyc(0, 0, 1, 0, 2'd0, 0, 0);
    check("t2_credit50", credit_o, 50);
    expect_ev(EV_REJECT, 0, 0);
    cyc(0, 0, 1, 0, 2'd0, 0, 0);
    check("t2_credit_hold", credit_o, 50);
    expect_ev(EV_REQ, 3, 5);
    cyc(0, 0, 0, 1, 2'd3, 0, 0);
    expect_ev(EV_NICK, 0, 0);
    cyc(0, 0, 0, 0, 2'd0, 0, 1);
    wait_idle("t2");

    // Dime, select 2 denied, cancel refunds the dime.
    cyc(0, 1, 0, 0, 2'd0, 0, 0);
    check("t3_credit", credit_o, 10);
    expect_ev(EV_DENY, 0, 0);
    cyc(0, 0, 0, 1, 2'd2, 0, 0);
    check("t3_credit_hold", credit_o, 10);
    check("t3_no_req", dispense_req_o, 0);
    expect_ev(EV_DIME, 0, 0);
    cyc(0, 0, 0, 0, 2'd0, 1, 0);
    wait_idle("t3");

    // Two coins at once: both rejected.
    expect_ev(EV_REJECT, 0, 0);
    cyc(1, 1, 0, 0, 2'd0, 0, 0);
    check("t4_credit", credit_o, 0);
    check("t4_busy", busy_o, 0);

    // 35 cents, select 0, ack held off 5 cycles; a coin during dispense is rejected.
    cyc(0, 0, 1, 0, 2'd0, 0, 0);
    cyc(0, 1, 0, 0, 2'd0, 0, 0);
    check("t5_credit", credit_o, 35);
    expect_ev(EV_REQ, 0, 15);
    cyc(0, 0, 0, 1, 2'd0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        expect_ev(EV_REJECT, 0, 0);
        cyc(1, 0, 0, 0, 2'd0, 0, 0);
      end else begin
        idle(1);
      end
      check("t5_req_hold", {dispense_req_o, product_o}, {1'b1, 2'd0});
      check("t5_remaining", credit_o, 15);
    end
    expect_ev(EV_DIME, 0, 5);
    expect_ev(EV_NICK, 0, 0);
    cyc(0, 0, 0, 0, 2'd0, 0, 1);
    check("t5_req_drop", dispense_req_o, 0);
    wait_idle("t5");

    // Exactly MAX_CREDIT accepted, nickle beyond rejected, cancel pays six dimes.
    cyc(0, 0, 1, 0, 2'd0, 0, 0);
    cyc(0, 0, 1, 0, 2'd0, 0, 0);
    cyc(0, 1, 0, 0, 2'd0, 0, 0);
    check("t6_credit60", credit_o, 60);
    expect_ev(EV_REJECT, 0, 0);
    cyc(1, 0, 0, 0, 2'd0, 0, 0);
    check("t6_credit_hold", credit_o, 60);
    for (int i = 5; i >= 0; i--) expect_ev(EV_DIME, 0, i * 10);
    cyc(0, 0, 0, 0, 2'd0, 1, 0);
    wait_idle("t6");

    // Select from IDLE with a same-cycle quarter: price uses old credit, quarter still counts.
    expect_ev(EV_DENY, 0, 0);
    cyc(0, 0, 1, 1, 2'd0, 0, 0);
    check("t7_credit", credit_o, 25);
    check("t7_busy", busy_o, 0);
    expect_ev(EV_DIME, 0, 15);
    expect_ev(EV_DIME, 0, 5);
    expect_ev(EV_NICK, 0, 0);
    cyc(0, 0, 0, 1, 2'd1, 1, 0);
    wait_idle("t7");

    // Cancel and ack in IDLE are ignored.
    cyc(0, 0, 0, 0, 2'd0, 1, 0);
    cyc(0, 0, 0, 0, 2'd0, 0, 1);
    check("t8_busy", busy_o, 0);
    check("t8_req", dispense_req_o, 0);

    // Asynchronous reset in the middle of a dispense.
    cyc(0, 0, 1, 0, 2'd0, 0, 0);
    expect_ev(EV_REQ, 2'd0, 5);
    cyc(0, 0, 0, 1, 2'd0, 0, 0);
    idle(1);
    #2 rst_ni = 1'b0;
    #1;
    check("t9_req", dispense_req_o, 0);
    check("t9_credit", credit_o, 0);
    check("t9_busy", busy_o, 0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;

`ifdef VEND_TIMEOUT_EN
    expect_ev(EV_DIME, 0, 0);
    cyc(0, 1, 0, 0, 2'd0, 0, 0);
    k = 0;
    while (!pay_dime_o && k < 20) begin
      @(posedge clk_i); #1;
      k++;
    end
    check("t10_tmo_latency", k, 8);
    wait_idle("t10");
`else
    k = 0;
    cyc(0, 1, 0, 0, 2'd0, 0, 0);
    idle(12);
    check("t10_no_tmo_busy", busy_o, k);
    check("t10_no_tmo_credit", credit_o, 10);
    expect_ev(EV_DIME, 0, 0);
    cyc(0, 0, 0, 0, 2'd0, 1, 0);
    wait_idle("t10");
`endif

    idle(3);
    check("sb_drain", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
# vend_controller

Transaction sequencer for the soda vending machine. Accepts coins into a credit register, handles a 4-way product selection with per-product prices, and drives a req/ack handshake to the dispenser mechanism. It then pays out change one coin per cycle, dimes first. It sits between the front panel (coin slot, buttons) and the dispenser/coin-hopper actuators, and generalises the single-product accept/dispense path to multiple priced products with cancel and refund.

## Interface
- `MAX_CREDIT`, default 60: credit ceiling in cents; multiple of 5, ≤ 63.
- `TIMEOUT_CYCLES`, default 1000: idle cycles in CREDIT before auto-refund (used only with `VEND_TIMEOUT_EN`).
- `clk_i`  in  1  clock. One clock domain, rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `nickle_i`, `dime_i`, `quarter_i`  in  1 each  coin pulses, one cycle per coin.
- `sel_valid_i`  in  1  selection strobe.
- `sel_i`  in  2  product index, sampled when `sel_valid_i` is high.
- `cancel_i`  in  1  refund request pulse.
- `dispense_ack_i`  in  1  dispenser done.
- `dispense_req_o`  out  1  dispense request, level.
- `product_o`  out  2  product being dispensed; valid while `dispense_req_o` is high.
- `pay_dime_o`, `pay_nickle_o`  out  1 each  change-coin pulses.
- `coin_reject_o`  out  1  pulse: coin returned, not credited.
- `denied_o`  out  1  pulse: selection refused for insufficient credit.
- `busy_o`  out  1  high in DISPENSE or PAYOUT.
- `credit_o`  out  6  current credit in cents.

## Operation
- Prices are fixed: product 0 = 20, 1 = 25, 2 = 35, 3 = 45 cents.
- States:
  - IDLE: credit is 0.
  - CREDIT: credit > 0, waiting for selection.
  - DISPENSE
  - PAYOUT
- Coins:
  - Coins are accepted only in IDLE and CREDIT.
  - More than one coin input high in the same cycle: all are ignored and `coin_reject_o` pulses.
  - A coin that would take credit above `MAX_CREDIT` is rejected; credit is unchanged.
  - Coins arriving in DISPENSE or PAYOUT are rejected.
  - An accepted coin in IDLE moves the FSM to CREDIT.
- Selection, valid in IDLE or CREDIT:
  - Price is compared against the registered credit, which excludes any coin arriving in the same cycle.
  - If credit ≥ price: go to DISPENSE and set remaining = credit + same-cycle accepted coin − price.
  - Otherwise: `denied_o` pulses, the same-cycle coin is still credited, and the state is unchanged.
- Cancel in CREDIT moves to PAYOUT with remaining = credit (full refund). Cancel in IDLE, DISPENSE or PAYOUT is ignored.
- Cancel and select in the same cycle: cancel wins.
- DISPENSE:
  - `dispense_req_o` stays high with `product_o` stable until a cycle in which `dispense_ack_i` is high.
  - On ack: go to PAYOUT if remaining > 0, else IDLE.
  - Ack while not in DISPENSE is ignored.
- PAYOUT:
  - Each cycle, pulse `pay_dime_o` if remaining ≥ 10, else pulse `pay_nickle_o`; subtract the coin value.
  - Exactly one pay pulse per cycle.
  - Go to IDLE in the cycle after remaining reaches 0.
- `credit_o` shows remaining during DISPENSE and PAYOUT; it is 0 in IDLE.
- All credit arithmetic is 6-bit unsigned and can never underflow: every subtraction is guarded by a comparison.

## Timing
- Reset: state IDLE, credit 0; every output 0. Assertion mid-transaction drops credit and any pending request immediately (asynchronous).
- Coin at cycle N is visible on `credit_o` at N+1.
- `coin_reject_o` and `denied_o` are registered: they pulse at N+1 for an event at N.
- Valid selection at N: `dispense_req_o` and `product_o` are high/valid from N+1.
- Ack at M:
  - `dispense_req_o` is low at M+1.
  - If change is due, the first pay pulse is at M+1.
- Change of C cents takes ⌊C/10⌋ + (C mod 10)/5 consecutive pulse cycles, then IDLE.

## Configuration
- `VEND_TIMEOUT_EN` defined:
  - A cycle counter runs in CREDIT and is cleared by every accepted coin and every denied selection.
  - On reaching `TIMEOUT_CYCLES`, the FSM enters PAYOUT with a full refund, exactly like cancel.
- Not defined: the counter logic is absent and CREDIT waits indefinitely.

## Structure
- Package `vend_pkg` holds:
  - state enum `vend_state_e`
  - coin value constants (5/10/25)
  - price array `PRICE[4]`
  - credit width constant (6)
- Sub-module `change_payout`:
  - Loads the remaining amount on a start strobe.
  - Emits the dime/nickle pulse sequence.
  - Raises `done` on the last pulse.
  - The FSM waits on `done` to return to IDLE.

## Test plan
- Quarter, then select 0 → `dispense_req_o` high, `product_o` = 0. Ack → one `pay_nickle_o` pulse, then IDLE, credit 0.
- Quarter ×2 (credit 50), then another coin → `coin_reject_o` pulse, credit stays 50. Select 3, ack → one nickle.
- Dime, then select 2 → `denied_o` pulse, credit stays 10. Cancel → one `pay_dime_o` pulse, IDLE.
- Dime + nickle on the same cycle → `coin_reject_o` pulse, credit 0.
- Quarter + dime (35), select 0, hold ack low 5 cycles → req held 5 cycles. Ack → pulses dime, nickle.
- Quarter, then `rst_ni` low mid-DISPENSE → outputs 0 at once, credit 0. With `VEND_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8: a single dime is refunded after 8 idle cycles.
